sram_burst_model: RTL and testbench
===================================

Name: sram_burst_model

Overview:
- Parametrised, cycle-accurate behavioural SRAM model; next generation of the team's fixed-width SRAM model.
- Replaces the inout data bus and delay-based read timing with a valid/ready request port, a configurable read latency in clock cycles, byte-masked writes and aligned burst reads of BURST_LEN words.
- Sits behind the memory-stage SRAM controller in the pipelined processor.
- Accepts one request at a time.

Parameters:
- DATA_W, 32, word width in bits; must be a multiple of 8.
- ADDR_W, 10, word address width.
- DEPTH, 1024, number of words; must equal 2**ADDR_W.
- BURST_LEN, 2, words returned per read; power of two, 1..8.
- RD_LAT, 3, cycles from read acceptance to rsp_valid; range 1..15.
- WR_LAT, 2, cycles from write acceptance to wr_done; range 1..15.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  reset; synchronous, active-low.
- req_valid  input  1  request present.
- req_ready  output  1  model can accept a request this cycle.
- req_we  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_W  word address.
- req_wdata  input  DATA_W  write data.
- req_be  input  DATA_W/8  byte enables for writes; bit i covers bits 8i+7:8i.
- rsp_valid  output  1  one-cycle pulse; rsp_data holds a valid burst.
- rsp_data  output  BURST_LEN*DATA_W  burst data; word k is at bits (k+1)*DATA_W-1:k*DATA_W.
- wr_done  output  1  one-cycle pulse; write committed.
- busy  output  1  request in flight; equals ~req_ready.

Behaviour:
- Reset (rst==0 at a rising edge):
  - State returns to IDLE.
  - req_ready=1, busy=0, rsp_valid=0, wr_done=0, rsp_data=0, latency counter=0.
  - Memory array is NOT cleared.
- Handshake: a request is accepted on an edge where req_valid & req_ready. req_addr, req_we, req_wdata and req_be are latched at that edge. Inputs are ignored while busy.
- FSM states: IDLE, WR_WAIT, RD_WAIT.
  - IDLE: accept with req_we=1 -> WR_WAIT, counter=WR_LAT-1. Accept with req_we=0 -> RD_WAIT, counter=RD_LAT-1.
  - WR_WAIT: counter decrements each cycle. At counter==0, the next edge commits the enabled bytes of the latched data to mem[addr], pulses wr_done for one cycle and returns to IDLE. Disabled bytes keep their old value.
  - RD_WAIT: counter decrements each cycle. At counter==0, the next edge loads rsp_data, pulses rsp_valid for one cycle and returns to IDLE.
- Read burst: base = latched addr with its low log2(BURST_LEN) bits forced to 0. Word k = mem[base+k]. No wrap inside a burst is possible because the base is aligned.
- Latency: a request accepted at edge T raises rsp_valid (or wr_done) after edge T+RD_LAT (or T+WR_LAT). req_ready rises in the same cycle as the pulse, so a new request can be accepted on the following edge. Back-to-back throughput is one request per LAT+1 cycles.
- rsp_data holds its last value until the next read completes or reset.
- Address wrap: addresses are word indices modulo DEPTH; no out-of-range condition exists.
- Write with req_be all zero: no memory change, wr_done still pulses.
- Reset mid-operation: an uncommitted write is dropped (memory unchanged) and a pending read is discarded (no rsp_valid).
- Reset and commit on the same edge: reset wins; no write, no pulse.
- Read-after-write: a read accepted after wr_done returns the newly written data.

Test Plan:
- Reset then idle: drive rst=0 for 2 cycles, then rst=1 -> req_ready=1, busy=0, rsp_valid=0, wr_done=0, rsp_data=0.
- Full write then burst read (defaults): write 0xDEADBEEF to addr 4 with be=4'hF, then 0x12345678 to addr 5. Read addr 5 -> rsp_valid exactly 3 cycles after acceptance, rsp_data=64'h12345678_DEADBEEF; wr_done came 2 cycles after each write acceptance.
- Byte mask: mem[8]=0xAABBCCDD; write 0x11223344 to addr 8 with be=4'b0101, then read addr 8 -> word 0 = 0xAA22CC44.
- Busy gating: during RD_WAIT assert req_valid, req_we=1, addr 6 -> not accepted, mem[6] unchanged, req_ready=0 until the rsp_valid cycle.
- Reset mid-write: accept a write of 0xFFFFFFFF to addr 10 (previously 0), assert rst=0 the next cycle -> no wr_done, and a later read of addr 10 returns 0.
- Parameter sweep: BURST_LEN=4, RD_LAT=1, DEPTH=16. Read addr 15 -> base 12, rsp_data = {mem[15],mem[14],mem[13],mem[12]}, rsp_valid on the cycle after acceptance.

Source files
------------

// File: rtl/sram_burst_model.sv
// Cycle-accurate SRAM model: valid/ready request port, fixed read/write latency,
// byte-masked writes and aligned burst reads of BURST_LEN words.
module sram_burst_model #(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 10,
   parameter int DEPTH     = 1024,
   parameter int BURST_LEN = 2,
   parameter int RD_LAT    = 3,
   parameter int WR_LAT    = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          req_valid,
   output logic                          req_ready,
   input  logic                          req_we,
   input  logic [ADDR_W-1:0]             req_addr,
   input  logic [DATA_W-1:0]             req_wdata,
   input  logic [DATA_W/8-1:0]           req_be,
   output logic                          rsp_valid,
   output logic [BURST_LEN*DATA_W-1:0]   rsp_data,
   output logic                          wr_done,
   output logic                          busy
);

   localparam int BE_W = DATA_W / 8;

   typedef enum logic [1:0] {IDLE, WR_WAIT, RD_WAIT} state_t;

   state_t                   state;
   logic [3:0]               cnt;
   logic [ADDR_W-1:0]        addr_q;
   logic [DATA_W-1:0]        wdata_q;
   logic [BE_W-1:0]          be_q;
   logic [ADDR_W-1:0]        base;
   logic [BURST_LEN*DATA_W-1:0] burst;
   logic                     commit;

   logic [DATA_W-1:0] mem [DEPTH];

   assign busy   = ~req_ready;
   assign commit = (state == WR_WAIT) && (cnt == '0);
   // Aligned base: clearing the low bits means base+k never crosses the array end.
   assign base   = addr_q & ~ADDR_W'(BURST_LEN - 1);

   always_comb begin
      burst = '0;
      for (int unsigned k = 0; k < BURST_LEN; k++) begin
         burst[k*DATA_W +: DATA_W] = mem[base + ADDR_W'(k)];
      end
   end

   // Array is never reset; a reset on the commit edge suppresses the write.
   always_ff @(posedge clk) begin
      if (rst && commit) begin
         for (int unsigned i = 0; i < BE_W; i++) begin
            if (be_q[i]) mem[addr_q][i*8 +: 8] <= wdata_q[i*8 +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         wr_done   <= 1'b0;
         rsp_data  <= '0;
         cnt       <= '0;
      end else begin
         rsp_valid <= 1'b0;
         wr_done   <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid && req_ready) begin
                  addr_q    <= req_addr;
                  wdata_q   <= req_wdata;
                  be_q      <= req_be;
                  req_ready <= 1'b0;
                  if (req_we) begin
                     state <= WR_WAIT;
                     cnt   <= 4'(WR_LAT - 1);
                  end else begin
                     state <= RD_WAIT;
                     cnt   <= 4'(RD_LAT - 1);
                  end
               end
            end
            WR_WAIT: begin
               if (cnt == '0) begin
                  wr_done   <= 1'b1;
                  req_ready <= 1'b1;
                  state     <= IDLE;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            RD_WAIT: begin
               if (cnt == '0) begin
                  rsp_data  <= burst;
                  rsp_valid <= 1'b1;
                  req_ready <= 1'b1;
                  state     <= IDLE;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            default: begin
               state     <= IDLE;
               req_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sram_burst_model.sv
// Directed bench for sram_burst_model: default instance (a) plus a
// BURST_LEN=4 / RD_LAT=1 / DEPTH=16 instance (b).
module tb_sram_burst_model;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   logic        a_req_valid = 0, a_req_we = 0;
   logic [9:0]  a_req_addr = '0;
   logic [31:0] a_req_wdata = '0;
   logic [3:0]  a_req_be = '0;
   logic        a_req_ready, a_rsp_valid, a_wr_done, a_busy;
   logic [63:0] a_rsp_data;

   logic        b_req_valid = 0, b_req_we = 0;
   logic [3:0]  b_req_addr = '0;
   logic [31:0] b_req_wdata = '0;
   logic [3:0]  b_req_be = '0;
   logic        b_req_ready, b_rsp_valid, b_wr_done, b_busy;
   logic [127:0] b_rsp_data;

   sram_burst_model dut_a (
      .clk(clk), .rst(rst), .req_valid(a_req_valid), .req_ready(a_req_ready),
      .req_we(a_req_we), .req_addr(a_req_addr), .req_wdata(a_req_wdata),
      .req_be(a_req_be), .rsp_valid(a_rsp_valid), .rsp_data(a_rsp_data),
      .wr_done(a_wr_done), .busy(a_busy));

   sram_burst_model #(.DATA_W(32), .ADDR_W(4), .DEPTH(16), .BURST_LEN(4),
                      .RD_LAT(1), .WR_LAT(2)) dut_b (
      .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_ready(b_req_ready),
      .req_we(b_req_we), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
      .req_be(b_req_be), .rsp_valid(b_rsp_valid), .rsp_data(b_rsp_data),
      .wr_done(b_wr_done), .busy(b_busy));

   function automatic logic rdy(input bit sel);
      return sel ? b_req_ready : a_req_ready;
   endfunction

   function automatic logic done(input bit sel);
      return sel ? b_wr_done : a_wr_done;
   endfunction

   function automatic logic rvalid(input bit sel);
      return sel ? b_rsp_valid : a_rsp_valid;
   endfunction

   function automatic logic [127:0] rdata(input bit sel);
      return sel ? b_rsp_data : {64'b0, a_rsp_data};
   endfunction

   task automatic drive(input bit sel, input logic v, input logic we,
                        input logic [9:0] addr, input logic [31:0] d, input logic [3:0] be);
      if (sel) begin
         b_req_valid = v; b_req_we = we; b_req_addr = addr[3:0]; b_req_wdata = d; b_req_be = be;
      end else begin
         a_req_valid = v; a_req_we = we; a_req_addr = addr; a_req_wdata = d; a_req_be = be;
      end
   endtask

   // Waits (bounded) for ready, presents the request for exactly one edge.
   task automatic issue(input bit sel, input logic we, input logic [9:0] addr,
                        input logic [31:0] d, input logic [3:0] be, output int waited);
      @(negedge clk);
      waited = 0;
      while (!rdy(sel) && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      drive(sel, 1'b1, we, addr, d, be);
      @(posedge clk);
      #1;
      drive(sel, 1'b0, 1'b0, '0, '0, '0);
   endtask

   task automatic do_write(input bit sel, input logic [9:0] addr, input logic [31:0] d,
                           input logic [3:0] be, output int lat);
      int waited;
      issue(sel, 1'b1, addr, d, be, waited);
      lat = -1;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk);
         #1;
         if (done(sel)) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic do_read(input bit sel, input logic [9:0] addr, output int lat,
                          output int waited, output logic [127:0] data);
      issue(sel, 1'b0, addr, '0, '0, waited);
      lat  = -1;
      data = 'x;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk);
         #1;
         if (rvalid(sel)) begin
            lat  = i;
            data = rdata(sel);
            break;
         end
      end
   endtask

   task automatic test_reset;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++; if (a_req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", a_req_ready); end
      checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", a_busy); end
      checks++; if (a_rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", a_rsp_valid); end
      checks++; if (a_wr_done !== 1'b0) begin errors++; $display("FAIL reset_wr_done got=%b exp=0", a_wr_done); end
      checks++; if (a_rsp_data !== 64'h0) begin errors++; $display("FAIL reset_rsp_data got=%h exp=0", a_rsp_data); end
      checks++; if (b_req_ready !== 1'b1 || b_rsp_data !== 128'h0) begin
         errors++; $display("FAIL reset_b got ready=%b data=%h exp 1/0", b_req_ready, b_rsp_data);
      end
   endtask

   task automatic test_write_burst;
      int lat, w;
      logic [127:0] d;
      do_write(0, 10'd4, 32'hDEADBEEF, 4'hF, lat);
      checks++; if (lat !== 2) begin errors++; $display("FAIL wr_lat_4 got=%0d exp=2", lat); end
      do_write(0, 10'd5, 32'h12345678, 4'hF, lat);
      checks++; if (lat !== 2) begin errors++; $display("FAIL wr_lat_5 got=%0d exp=2", lat); end
      do_read(0, 10'd5, lat, w, d);
      checks++; if (lat !== 3) begin errors++; $display("FAIL rd_lat got=%0d exp=3", lat); end
      checks++; if (d[63:0] !== 64'h12345678_DEADBEEF) begin
         errors++; $display("FAIL burst_data got=%h exp=12345678deadbeef", d[63:0]);
      end
   endtask

   task automatic test_byte_mask;
      int lat, w;
      logic [127:0] d;
      do_write(0, 10'd8, 32'hAABBCCDD, 4'hF, lat);
      do_write(0, 10'd9, 32'h99999999, 4'hF, lat);
      do_write(0, 10'd8, 32'h11223344, 4'b0101, lat);
      do_write(0, 10'd9, 32'h0BADF00D, 4'b0000, lat);
      checks++; if (lat !== 2) begin errors++; $display("FAIL be_zero_done got=%0d exp=2", lat); end
      do_read(0, 10'd8, lat, w, d);
      checks++; if (d[63:0] !== 64'h99999999_AA22CC44) begin
         errors++; $display("FAIL byte_mask got=%h exp=99999999aa22cc44", d[63:0]);
      end
   endtask

   task automatic test_busy_gating;
      int lat, w, seen;
      bit bad_ready;
      logic [127:0] d;
      do_write(0, 10'd6, 32'h66666666, 4'hF, lat);
      do_write(0, 10'd7, 32'h77777777, 4'hF, lat);
      @(negedge clk);
      drive(0, 1'b1, 1'b0, 10'd6, '0, '0);
      @(posedge clk);
      #1;
      drive(0, 1'b1, 1'b1, 10'd6, 32'h55555555, 4'hF);
      seen = -1;
      bad_ready = 0;
      d = '0;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk);
         #1;
         if (a_rsp_valid) begin
            seen = i;
            d = {64'b0, a_rsp_data};
            checks++; if (a_req_ready !== 1'b1) begin errors++; $display("FAIL ready_at_rsp got=%b exp=1", a_req_ready); end
            break;
         end else if (a_req_ready !== 1'b0 || a_busy !== 1'b1) begin
            bad_ready = 1;
         end
      end
      drive(0, 1'b0, 1'b0, '0, '0, '0);
      checks++; if (bad_ready !== 1'b0) begin errors++; $display("FAIL busy_ready got=ready_seen exp=ready_low"); end
      checks++; if (seen !== 3) begin errors++; $display("FAIL busy_rd_lat got=%0d exp=3", seen); end
      checks++; if (d[63:0] !== 64'h77777777_66666666) begin
         errors++; $display("FAIL busy_rd_data got=%h exp=7777777766666666", d[63:0]);
      end
      do_read(0, 10'd6, lat, w, d);
      checks++; if (d[63:0] !== 64'h77777777_66666666) begin
         errors++; $display("FAIL busy_no_write got=%h exp=7777777766666666", d[63:0]);
      end
   endtask

   task automatic test_back_to_back;
      int lat, w;
      logic [127:0] d;
      do_write(0, 10'd20, 32'hA5A5A5A5, 4'hF, lat);
      do_read(0, 10'd20, lat, w, d);
      checks++; if (w !== 0) begin errors++; $display("FAIL b2b_wait got=%0d exp=0", w); end
      checks++; if (d[31:0] !== 32'hA5A5A5A5) begin errors++; $display("FAIL raw_data got=%h exp=a5a5a5a5", d[31:0]); end
      do_read(0, 10'd4, lat, w, d);
      checks++; if (w !== 0 || lat !== 3) begin
         errors++; $display("FAIL b2b_read got wait=%0d lat=%0d exp 0/3", w, lat);
      end
   endtask

   // rst_at: negedges after acceptance at which reset is applied for two edges.
   task automatic reset_during_write(input logic [9:0] addr, input int rst_at, input string nm);
      int lat, w;
      bit pulse;
      logic [127:0] d;
      do_write(0, addr, 32'h00000000, 4'hF, lat);
      issue(0, 1'b1, addr, 32'hFFFFFFFF, 4'hF, w);
      repeat (rst_at) @(negedge clk);
      rst = 1'b0;
      pulse = 0;
      repeat (2) begin
         @(posedge clk);
         #1;
         if (a_wr_done) pulse = 1;
      end
      @(negedge clk);
      rst = 1'b1;
      checks++; if (pulse !== 1'b0 || a_req_ready !== 1'b1) begin
         errors++; $display("FAIL %s_pulse got done=%b ready=%b exp 0/1", nm, pulse, a_req_ready);
      end
      do_read(0, addr, lat, w, d);
      checks++; if (d[31:0] !== 32'h0) begin errors++; $display("FAIL %s_mem got=%h exp=0", nm, d[31:0]); end
   endtask

   task automatic test_reset_mid_read;
      int w;
      bit pulse;
      issue(0, 1'b0, 10'd4, '0, '0, w);
      @(negedge clk);
      rst = 1'b0;
      pulse = 0;
      repeat (3) begin
         @(posedge clk);
         #1;
         if (a_rsp_valid) pulse = 1;
      end
      @(negedge clk);
      rst = 1'b1;
      checks++; if (pulse !== 1'b0 || a_rsp_data !== 64'h0) begin
         errors++; $display("FAIL rst_read got valid=%b data=%h exp 0/0", pulse, a_rsp_data);
      end
   endtask

   task automatic test_sweep;
      int lat, w;
      logic [127:0] d;
      for (int i = 12; i < 16; i++) begin
         do_write(1, 10'(i), 32'hC0DE0000 | 32'(i), 4'hF, lat);
      end
      checks++; if (lat !== 2) begin errors++; $display("FAIL sweep_wr_lat got=%0d exp=2", lat); end
      do_read(1, 10'd15, lat, w, d);
      checks++; if (lat !== 1) begin errors++; $display("FAIL sweep_rd_lat got=%0d exp=1", lat); end
      checks++; if (d !== 128'hC0DE000F_C0DE000E_C0DE000D_C0DE000C) begin
         errors++; $display("FAIL sweep_burst got=%h exp=c0de000fc0de000ec0de000dc0de000c", d);
      end
      do_read(1, 10'd13, lat, w, d);
      checks++; if (d !== 128'hC0DE000F_C0DE000E_C0DE000D_C0DE000C || w !== 0) begin
         errors++; $display("FAIL sweep_align got=%h wait=%0d exp=c0de000fc0de000ec0de000dc0de000c/0", d, w);
      end
   endtask

   initial begin
      test_reset();
      test_write_burst();
      test_byte_mask();
      test_busy_gating();
      test_back_to_back();
      reset_during_write(10'd10, 1, "rst_mid_write");
      reset_during_write(10'd11, 2, "rst_commit_edge");
      test_reset_mid_read();
      test_sweep();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
